// File: rtl/ball_motion_3d.sv
// ball_motion_3d: pseudo-3D pong ball. It moves in X/Y on screen and in Z
// between a near paddle plane and a far wall. It serves, flies, scores paddle
// hits, counts misses down from the initial lives and freezes at game over.
// All state advances only on frame ticks taken from the frame_clk level.
module ball_motion_3d #(
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int Z_MAX        = 255,
    parameter int X_STEP       = 2,
    parameter int Y_STEP       = 1,
    parameter int Z_STEP       = 3,
    parameter int PADDLE_W     = 200,
    parameter int PADDLE_H     = 150,
    parameter int SERVE_FRAMES = 60,
    parameter int LIVES        = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] paddleX,
    input  logic [9:0] paddleY,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       hit,
    output logic       miss,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int          CNT_W   = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [9:0]  X_SERVE = 10'd320;
    localparam logic [9:0]  Y_SERVE = 10'd240;
    localparam logic [7:0]  Z_SERVE = 8'(Z_MAX >> 1);
    localparam logic [7:0]  Z_TOP   = 8'(Z_MAX);
    localparam logic [7:0]  Z_STEP8 = 8'(Z_STEP);
    localparam logic [8:0]  Z_STEP9 = 9'(Z_STEP);
    localparam logic [8:0]  Z_MAX9  = 9'(Z_MAX);
    localparam logic [10:0] X_LIM   = 11'(X_MAX);
    localparam logic [10:0] Y_LIM   = 11'(Y_MAX);
    localparam logic [10:0] X_STP   = 11'(X_STEP);
    localparam logic [10:0] Y_STP   = 11'(Y_STEP);

    typedef enum logic [1:0] {S_SERVE, S_FLY, S_MISS, S_OVER} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [9:0]       x, y, x_n, y_n;
    logic [7:0]       z, z_n;
    logic             dx, dy, dz, dx_n, dy_n, dz_n;
    logic             hit_n, miss_n;
    logic [1:0]       lives_n;
    logic [7:0]       score_n;
    logic             fc_p0, fc_p1, fc_p2;
    logic             fc_warm, fc_armed;
    logic             tick;
    logic             in_x, in_y;

    // Hit counter that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One axis of wall bouncing: returns {new_dir, new_pos}. A bounce flips
    // the direction and holds the position for that frame.
    function automatic logic [10:0] axis_step(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [9:0]  size,
                                              input logic [10:0] step,
                                              input logic [10:0] lim);
        logic [10:0] p11;
        logic [10:0] s11;
        p11 = {1'b0, pos};
        s11 = {1'b0, size};
        if (dir) begin
            if (p11 + s11 + step > lim) return {1'b0, pos};
            else                        return {1'b1, pos + step[9:0]};
        end else begin
            if (p11 < s11 + step)       return {1'b1, pos};
            else                        return {1'b0, pos - step[9:0]};
        end
    endfunction

    // A frame_clk level that is already high when reset releases is not an
    // edge: ticks are armed only once the synchronised level has been seen low.
    assign tick      = fc_p1 & ~fc_p2 & fc_armed;
    assign Ball_size = 10'd4 + ((10'(Z_MAX) - {2'b0, z}) >> 3);
    assign in_x      = ({1'b0, x} >= {1'b0, paddleX}) &&
                       ({1'b0, x} <  {1'b0, paddleX} + 11'(PADDLE_W));
    assign in_y      = ({1'b0, y} >= {1'b0, paddleY}) &&
                       ({1'b0, y} <  {1'b0, paddleY} + 11'(PADDLE_H));
    assign BallX     = x;
    assign BallY     = y;
    assign game_over = (state == S_OVER);

    // Synchronise frame_clk and keep the previous level for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_p0    <= 1'b0;
            fc_p1    <= 1'b0;
            fc_p2    <= 1'b0;
            fc_warm  <= 1'b0;
            fc_armed <= 1'b0;
        end else begin
            fc_p0    <= frame_clk;
            fc_p1    <= fc_p0;
            fc_p2    <= fc_p1;
            fc_warm  <= 1'b1;
            fc_armed <= fc_armed | (fc_warm & ~fc_p0);
        end
    end

    // Next-state and next-ball computation; nothing moves outside a tick.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = x;
        y_n     = y;
        z_n     = z;
        dx_n    = dx;
        dy_n    = dy;
        dz_n    = dz;
        hit_n   = hit;
        miss_n  = miss;
        lives_n = lives;
        score_n = score;
        if (tick) begin
            hit_n  = 1'b0;
            miss_n = 1'b0;
            case (state)
                S_SERVE: begin
                    x_n  = X_SERVE;
                    y_n  = Y_SERVE;
                    z_n  = Z_SERVE;
                    dx_n = 1'b1;
                    dy_n = 1'b1;
                    dz_n = 1'b0;
                    if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_n = S_FLY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_FLY: begin
                    {dx_n, x_n} = axis_step(x, dx, Ball_size, X_STP, X_LIM);
                    {dy_n, y_n} = axis_step(y, dy, Ball_size, Y_STP, Y_LIM);
                    if (dz && ({1'b0, z} + Z_STEP9 >= Z_MAX9)) begin
                        z_n  = Z_TOP;
                        dz_n = 1'b0;
                    end else if (!dz && ({1'b0, z} <= Z_STEP9)) begin
                        z_n = 8'd0;
                        if (in_x && in_y) begin
                            dz_n    = 1'b1;
                            hit_n   = 1'b1;
                            score_n = sat_inc8(score);
                        end else begin
                            miss_n  = 1'b1;
                            lives_n = lives - 2'd1;
                            state_n = (lives > 2'd1) ? S_MISS : S_OVER;
                        end
                    end else if (dz) begin
                        z_n = z + Z_STEP8;
                    end else begin
                        z_n = z - Z_STEP8;
                    end
                end
                S_MISS: begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                    x_n     = X_SERVE;
                    y_n     = Y_SERVE;
                    z_n     = Z_SERVE;
                    dx_n    = 1'b1;
                    dy_n    = 1'b1;
                    dz_n    = 1'b0;
                end
                S_OVER: begin
                end
            endcase
        end
    end

    // Game state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_SERVE;
            cnt   <= '0;
            x     <= X_SERVE;
            y     <= Y_SERVE;
            z     <= Z_SERVE;
            dx    <= 1'b1;
            dy    <= 1'b1;
            dz    <= 1'b0;
            hit   <= 1'b0;
            miss  <= 1'b0;
            lives <= 2'(LIVES);
            score <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            x     <= x_n;
            y     <= y_n;
            z     <= z_n;
            dx    <= dx_n;
            dy    <= dy_n;
            dz    <= dz_n;
            hit   <= hit_n;
            miss  <= miss_n;
            lives <= lives_n;
            score <= score_n;
        end
    end

endmodule

// File: tb/tb_ball_motion_3d.sv
// tb_ball_motion_3d: directed table of frame sequences with hand-computed
// ball positions, plus reset sequences around frame_clk edges.
module tb_ball_motion_3d;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b1;
    logic [9:0] paddleX = 10'd0;
    logic [9:0] paddleY = 10'd0;
    logic [9:0] BallX, BallY, Ball_size;
    logic       hit, miss, game_over;
    logic [1:0] lives;
    logic [7:0] score;

    int n_vec = 0;
    int n_bad = 0;
    int both_cnt = 0;

    ball_motion_3d dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .paddleX   (paddleX),
        .paddleY   (paddleY),
        .BallX     (BallX),
        .BallY     (BallY),
        .Ball_size (Ball_size),
        .hit       (hit),
        .miss      (miss),
        .lives     (lives),
        .score     (score),
        .game_over (game_over)
    );

    always #5 Clk = ~Clk;

    // op 0: apply nt frame ticks with the given paddle; op 1: reset pulse
    // with frame_clk rising alongside it and held high past release.
    typedef struct {
        int op;
        int nt;
        int px, py;
        int ex, ey, es;
        int eh, em, el, esc, ego;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int op, int nt, int px, int py, int ex, int ey, int es,
                                int eh, int em, int el, int esc, int ego);
        vec_t v;
        v.op = op; v.nt = nt; v.px = px; v.py = py;
        v.ex = ex; v.ey = ey; v.es = es;
        v.eh = eh; v.em = em; v.el = el; v.esc = esc; v.ego = ego;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0d, expected %0d", idx, name, act, exp);
        end
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic reset_pulse(input int idx);
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_next_clk_x", idx, BallX, 320);
        chk("rst_next_clk_size", idx, Ball_size, 20);
        chk("rst_next_clk_hit", idx, hit, 0);
        chk("rst_next_clk_lives", idx, lives, 3);
        chk("rst_next_clk_over", idx, game_over, 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    // hit and miss must never be high together.
    always @(negedge Clk) if (hit && miss) both_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // serve, hit at upper paddle edges, far wall, right wall bounce
        tv.push_back(mk(0, 60,   0,   0, 320, 240, 20, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,  1,   0,   0, 322, 241, 20, 0, 0, 3, 0, 0));
        tv.push_back(mk(0, 41,   0,   0, 404, 282, 35, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,  1, 205, 133, 406, 283, 35, 1, 0, 3, 1, 0));
        tv.push_back(mk(0,  1, 205, 133, 408, 284, 35, 0, 0, 3, 1, 0));
        tv.push_back(mk(0, 84,   0,   0, 576, 368,  4, 0, 0, 3, 1, 0));
        tv.push_back(mk(0,  3,   0,   0, 582, 371,  5, 0, 0, 3, 1, 0));
        tv.push_back(mk(0, 22,   0,   0, 626, 393, 13, 0, 0, 3, 1, 0));
        tv.push_back(mk(0,  1,   0,   0, 626, 394, 13, 0, 0, 3, 1, 0));
        tv.push_back(mk(0,  1,   0,   0, 624, 395, 14, 0, 0, 3, 1, 0));
        // reset mid-flight, then three misses on paddle edges
        tv.push_back(mk(1,  0,   0,   0, 320, 240, 20, 0, 0, 3, 0, 0));
        tv.push_back(mk(0, 60,   0,   0, 320, 240, 20, 0, 0, 3, 0, 0));
        tv.push_back(mk(0, 42,   0,   0, 404, 282, 35, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,  1, 204, 133, 406, 283, 35, 0, 1, 2, 0, 0));
        tv.push_back(mk(0,  1,   0,   0, 320, 240, 20, 0, 0, 2, 0, 0));
        tv.push_back(mk(0,102,   0,   0, 404, 282, 35, 0, 0, 2, 0, 0));
        tv.push_back(mk(0,  1, 205, 283, 406, 283, 35, 0, 1, 1, 0, 0));
        tv.push_back(mk(0,  1,   0,   0, 320, 240, 20, 0, 0, 1, 0, 0));
        tv.push_back(mk(0,102,   0,   0, 404, 282, 35, 0, 0, 1, 0, 0));
        tv.push_back(mk(0,  1, 205, 132, 406, 283, 35, 0, 1, 0, 0, 1));
        tv.push_back(mk(0,  1,   0,   0, 406, 283, 35, 0, 0, 0, 0, 1));
        tv.push_back(mk(0,  5, 205, 133, 406, 283, 35, 0, 0, 0, 0, 1));
        // reset out of game over, hit on lower edges, reset while hit high
        tv.push_back(mk(1,  0,   0,   0, 320, 240, 20, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,102,   0,   0, 404, 282, 35, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,  1, 404, 282, 406, 283, 35, 1, 0, 3, 1, 0));
        tv.push_back(mk(1,  0,   0,   0, 320, 240, 20, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,102,   0,   0, 404, 282, 35, 0, 0, 3, 0, 0));
        tv.push_back(mk(0,  1, 405, 282, 406, 283, 35, 0, 1, 2, 0, 0));
        tv.push_back(mk(0,  1,   0,   0, 320, 240, 20, 0, 0, 2, 0, 0));

        // reset with frame_clk already high; the held level must not tick
        repeat (3) @(negedge Clk);
        chk("reset_x", -1, BallX, 320);
        chk("reset_y", -1, BallY, 240);
        chk("reset_size", -1, Ball_size, 20);
        chk("reset_hit", -1, hit, 0);
        chk("reset_miss", -1, miss, 0);
        chk("reset_lives", -1, lives, 3);
        chk("reset_score", -1, score, 0);
        chk("reset_over", -1, game_over, 0);
        Reset = 1'b0;
        repeat (8) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].op == 1) begin
                reset_pulse(i);
            end else begin
                paddleX = 10'(tv[i].px);
                paddleY = 10'(tv[i].py);
                for (int k = 0; k < tv[i].nt; k++) frame_tick();
            end
            chk("ballx", i, BallX, tv[i].ex);
            chk("bally", i, BallY, tv[i].ey);
            chk("size", i, Ball_size, tv[i].es);
            chk("hit", i, hit, tv[i].eh);
            chk("miss", i, miss, tv[i].em);
            chk("lives", i, lives, tv[i].el);
            chk("score", i, score, tv[i].esc);
            chk("game_over", i, game_over, tv[i].ego);
        end

        chk("hit_miss_exclusive", -1, both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
